// File: rtl/counter_forward_if.sv
// Control/data bundle for counter_forward: the user side (master) drives the
// action strobes and configuration, the counter (slave) returns its value and flags.
interface counter_forward_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  clr_i;
    logic                  load_i;
    logic                  en_i;
    logic                  mode_i;
    logic [WORD_WIDTH-1:0] limit_i;
    logic [WORD_WIDTH-1:0] d_i;
    logic [WORD_WIDTH-1:0] d_o;
    logic                  will_overflow_o;
    logic                  overflow_o;

    modport master (
        output clr_i, load_i, en_i, mode_i, limit_i, d_i,
        input  d_o, will_overflow_o, overflow_o
    );

    modport slave (
        input  clr_i, load_i, en_i, mode_i, limit_i, d_i,
        output d_o, will_overflow_o, overflow_o
    );
endinterface

// File: rtl/counter_forward.sv
// Up-counter with inclusive programmable terminal value, wrap or saturate at the
// limit, synchronous clear/load, look-ahead and registered overflow flags.
module counter_forward #(
    parameter int WORD_WIDTH = 8
) (
    input logic              clk_i,
    input logic              arst_ni,
    counter_forward_if.slave bus
);

    logic [WORD_WIDTH-1:0] count_q;
    logic [WORD_WIDTH-1:0] count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  at_limit;

    // Value taken when an increment hits the limit: zero when wrapping, the limit
    // itself when saturating (this also clamps a value loaded above the limit).
    function automatic logic [WORD_WIDTH-1:0] terminal_value(
        input logic                  saturate,
        input logic [WORD_WIDTH-1:0] limit
    );
        return saturate ? limit : '0;
    endfunction

    // All-ones always satisfies this compare, so the increment never carries out.
    assign at_limit = (count_q >= bus.limit_i);

    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        if (bus.clr_i) begin
            count_d = '0;
        end else if (bus.load_i) begin
            count_d = bus.d_i;
        end else if (bus.en_i) begin
            if (at_limit) begin
                count_d    = terminal_value(bus.mode_i, bus.limit_i);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + WORD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.d_o             = count_q;
    assign bus.overflow_o      = overflow_q;
    assign bus.will_overflow_o = at_limit;

endmodule

// File: tb/tb_counter_forward.sv
// Randomised and directed bench for counter_forward against a behavioural model,
// plus a two-stage 4-bit cascade.
module tb_counter_forward;

    logic clk_i   = 1'b0;
    logic arst_ni = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_i = ~clk_i;

    counter_forward_if #(.WORD_WIDTH(8)) bus ();
    counter_forward_if #(.WORD_WIDTH(4)) lo_bus ();
    counter_forward_if #(.WORD_WIDTH(4)) hi_bus ();

    counter_forward #(.WORD_WIDTH(8)) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (bus)
    );

    counter_forward #(.WORD_WIDTH(4)) dut_lo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (lo_bus)
    );

    counter_forward #(.WORD_WIDTH(4)) dut_hi (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (hi_bus)
    );

    logic casc_en = 1'b0;
    assign lo_bus.en_i = casc_en;
    assign hi_bus.en_i = casc_en & lo_bus.will_overflow_o;

    // Model state of the 8-bit counter
    int unsigned model_count = 0;
    bit          model_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the counter rules, check after the edge.
    task automatic step(input bit c, input bit l, input bit e, input bit m,
                        input logic [7:0] lim, input logic [7:0] dat);
        bus.clr_i   = c;
        bus.load_i  = l;
        bus.en_i    = e;
        bus.mode_i  = m;
        bus.limit_i = lim;
        bus.d_i     = dat;
        if (c) begin
            model_count = 0;
            model_ovf   = 0;
        end else if (l) begin
            model_count = int'(dat);
            model_ovf   = 0;
        end else if (e) begin
            if (model_count >= int'(lim)) begin
                model_ovf   = 1;
                model_count = m ? int'(lim) : 0;
            end else begin
                model_count = (model_count + 1) % 256;
                model_ovf   = 0;
            end
        end else begin
            model_ovf = 0;
        end
        @(posedge clk_i);
        #1;
        check("d_o", 32'(bus.d_o), 32'(model_count));
        check("overflow_o", 32'(bus.overflow_o), 32'(model_ovf));
        check("will_overflow_o", 32'(bus.will_overflow_o), 32'(model_count >= int'(lim)));
    endtask

    task automatic async_reset_check(input logic [7:0] lim);
        bus.limit_i = lim;
        arst_ni = 1'b0;
        #2;
        model_count = 0;
        model_ovf   = 0;
        check("reset d_o", 32'(bus.d_o), 32'd0);
        check("reset overflow_o", 32'(bus.overflow_o), 32'd0);
        check("reset will_overflow_o", 32'(bus.will_overflow_o), 32'(lim == 8'd0));
        arst_ni = 1'b1;
    endtask

    initial begin
        int combined;
        bus.clr_i = 0; bus.load_i = 0; bus.en_i = 0; bus.mode_i = 0;
        bus.limit_i = 8'hFF; bus.d_i = 8'h00;
        lo_bus.clr_i = 0; lo_bus.load_i = 0; lo_bus.mode_i = 0; lo_bus.limit_i = 4'hF; lo_bus.d_i = 4'h0;
        hi_bus.clr_i = 0; hi_bus.load_i = 0; hi_bus.mode_i = 0; hi_bus.limit_i = 4'hF; hi_bus.d_i = 4'h0;

        #12;
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset between edges from a loaded 0x37
        step(0, 1, 0, 0, 8'hFF, 8'h37);
        async_reset_check(8'h00);

        // Wrap at 4: 1,2,3,4,0,1
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h04, 8'h00);

        // Saturate with over-limit load
        step(0, 1, 0, 1, 8'h10, 8'h20);
        step(0, 0, 1, 1, 8'h10, 8'h00);
        step(0, 0, 1, 1, 8'h10, 8'h00);

        // Full-range binary around 0xFF
        step(0, 1, 0, 0, 8'hFF, 8'hFE);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'h00);

        // Priority
        step(0, 1, 0, 0, 8'hFF, 8'h05);
        step(1, 1, 1, 0, 8'hFF, 8'h33);
        step(0, 1, 1, 0, 8'hFF, 8'hAA);
        step(0, 0, 0, 0, 8'hFF, 8'h11);

        // Limit zero in both modes
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h00, 8'h00);

        // Randomised traffic with occasional mid-count resets
        for (int i = 0; i < 600; i++) begin
            logic [7:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 60) == 0) async_reset_check(lim);
            step($urandom_range(0, 30) == 0, $urandom_range(0, 10) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), lim, 8'($urandom_range(0, 20)));
        end

        // Cascade: preload 0x0F, then count from 0x00 through a full wrap
        lo_bus.load_i = 1; lo_bus.d_i = 4'hF;
        hi_bus.load_i = 1; hi_bus.d_i = 4'h0;
        @(posedge clk_i); #1;
        lo_bus.load_i = 0; hi_bus.load_i = 0;
        casc_en = 1;
        @(posedge clk_i); #1;
        check("cascade 0x0F->0x10", 32'({hi_bus.d_o, lo_bus.d_o}), 32'h10);
        check("cascade no hi pulse", 32'(hi_bus.overflow_o), 32'd0);
        casc_en = 0;
        lo_bus.clr_i = 1; hi_bus.clr_i = 1;
        @(posedge clk_i); #1;
        lo_bus.clr_i = 0; hi_bus.clr_i = 0;
        casc_en = 1;
        for (int i = 1; i <= 260; i++) begin
            @(posedge clk_i); #1;
            combined = i % 256;
            check("cascade value", 32'({hi_bus.d_o, lo_bus.d_o}), 32'(combined));
            check("cascade hi overflow", 32'(hi_bus.overflow_o), 32'(i == 256));
        end
        casc_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
